hit_injector: RTL and testbench
===============================

Name: hit_injector

Overview:
- Bus-programmable digital hit source for the Monopix2 simulation bench; sits directly upstream of the chip matrix and drives its analog_hit vector.
- Generates a delayed, width-controlled pulse train on one selected pixel or on all pixels.
- Replaces the static HIT input and the CLK_HIT gating scheme.
- Standard basil bus slave on BUS_CLK; software configures it through the same fx2_to_bus path as the other cores.

Parameters:
- BASEADDR, 16'h0000, first byte address of the register map.
- HIGHADDR, 16'h0000, last byte address.
- ABUSWIDTH, 16, bus address width.
- ROWS, 512, matrix rows.
- COLS, 56, matrix columns. The local constant N_PIX = ROWS*COLS.

Ports:
- BUS_CLK  in  1  single clock for bus and pulse sequencing
- BUS_RST  in  1  asynchronous, active-high reset
- BUS_ADD  in  ABUSWIDTH  bus address
- BUS_DATA  inout  8  bus data; driven only during reads inside [BASEADDR, HIGHADDR]
- BUS_RD  in  1  read strobe
- BUS_WR  in  1  write strobe
- HIT  out  N_PIX  per-pixel hit vector, index = col*ROWS + row
- HIT_OR  out  1  OR of HIT, registered in the same cycle as HIT
- BUSY  out  1  high while the sequencer is not IDLE

Behaviour:
- Reset (BUS_RST, or a soft reset write): all registers and counters return to 0, state goes to IDLE, HIT=0, HIT_OR=0, BUSY=0.
- Register map (byte offsets); all configuration registers are read/write:
  - 0: write = soft reset; read = VERSION 8'd1.
  - 1: write = START; read = {5'b0, ADDR_ERR, DONE, BUSY}.
  - 2/3: PIX_ADDR[15:0], little-endian.
  - 4/5: DELAY[15:0].
  - 6/7: WIDTH[15:0].
  - 8/9: PERIOD[15:0].
  - 10: REPEAT[7:0].
  - 11: write = STOP.
  - 12: {7'b0, ALL}.
- Read data is registered: it is valid on BUS_DATA in the cycle after BUS_RD.
- Shadowing: START copies all configuration into working registers. Writes made while BUSY take effect only at the next START.
- START while BUSY is ignored. START clears DONE and sets ADDR_ERR = (PIX_ADDR >= N_PIX) && !ALL.
- Pixel target: ADDR_ERR=1 keeps HIT all-zero, but the sequence still runs and sets DONE. ALL=1 drives every bit of HIT.
- States: IDLE -> DELAY -> HIGH -> LOW -> HIGH ... -> IDLE.
  - IDLE: on START, go to DELAY if DELAY>0, otherwise go straight to HIGH.
  - DELAY: lasts DELAY cycles, then HIGH.
  - HIGH: HIT asserted for max(WIDTH,1) cycles. It counts one pulse on exit.
  - After HIGH: if REPEAT!=0 and pulse count == REPEAT, go to IDLE and set DONE. Otherwise go to LOW.
  - LOW: lasts max(PERIOD-WIDTH,1) cycles. If PERIOD<=WIDTH, LOW is 1 cycle. Then HIGH.
- Timing: with START sampled on edge t, HIT first goes high on edge t+1+DELAY. Rising edges are spaced max(PERIOD, WIDTH+1) cycles apart.
- REPEAT=0 means the pulse train runs until STOP or reset. The pulse counter is 8 bits and stops at REPEAT.
- STOP in any non-IDLE state: go to IDLE on the next edge, HIT=0 on that same edge, DONE=1.
- If START and STOP land in the same cycle, STOP wins; with a single bus this cannot happen.
- The bus interface never back-pressures. Counters are 16 bits with no wrap: they count down to terminal, then reload.

Decomposition:
- Package hit_injector_pkg holds:
  - register offset constants;
  - the state enum (IDLE, DELAY, HIGH, LOW);
  - VERSION.
- Sub-modules:
  - hit_injector_core takes the IP_* interface and holds the registers and sequencer.
  - The top level hit_injector instantiates bus_to_ip plus hit_injector_core. This is the same wrapper/core split used by the other basil IPs.

Test Plan:
- Reset, then read offset 0 -> 8'h01. Read offset 1 -> 8'h00. HIT == 0.
- PIX_ADDR=5, DELAY=3, WIDTH=2, REPEAT=1, START at edge t -> HIT[5] high on edges t+4..t+5, all other bits 0. BUSY drops and DONE=1 at t+6. HIT_OR matches HIT[5].
- WIDTH=4, PERIOD=10, REPEAT=3, DELAY=0 -> three rising edges at t+1, t+11, t+21, each 4 cycles wide. Then IDLE and status == 8'h02.
- PERIOD=2, WIDTH=5 -> rising edges spaced 6 cycles apart. WIDTH=0 -> 1-cycle pulses.
- PIX_ADDR=N_PIX, ALL=0, START -> status bit2=1 and HIT stays 0 for the whole run; DONE=1 at the end. Set ALL=1 and START again -> all N_PIX bits pulse together.
- REPEAT=0 free-running; STOP mid-HIGH -> HIT=0 on the next edge and status == 8'h02. Assert BUS_RST mid-DELAY -> everything returns to 0 asynchronously. A START written while BUSY leaves the sequence unchanged.

Source files
------------

// File: rtl/hit_injector_pkg.sv
// Shared constants and types for the hit_injector pulse source.
package hit_injector_pkg;

    localparam logic [7:0] VERSION = 8'd1;

    localparam logic [3:0] REG_CTRL     = 4'd0;
    localparam logic [3:0] REG_STATUS   = 4'd1;
    localparam logic [3:0] REG_PIX_LO   = 4'd2;
    localparam logic [3:0] REG_PIX_HI   = 4'd3;
    localparam logic [3:0] REG_DELAY_LO = 4'd4;
    localparam logic [3:0] REG_DELAY_HI = 4'd5;
    localparam logic [3:0] REG_WIDTH_LO = 4'd6;
    localparam logic [3:0] REG_WIDTH_HI = 4'd7;
    localparam logic [3:0] REG_PER_LO   = 4'd8;
    localparam logic [3:0] REG_PER_HI   = 4'd9;
    localparam logic [3:0] REG_REPEAT   = 4'd10;
    localparam logic [3:0] REG_STOP     = 4'd11;
    localparam logic [3:0] REG_ALL      = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } state_e;

    // A zero-length phase still occupies one cycle.
    function automatic logic [15:0] max1(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

endpackage

// File: rtl/bus_to_ip.sv
// Address decode and registered-read data return for a basil bus slave.
module bus_to_ip #(
    parameter logic [15:0] BASEADDR  = 16'h0000,
    parameter logic [15:0] HIGHADDR  = 16'h0000,
    parameter int          ABUSWIDTH = 16
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    inout  wire  [7:0]           BUS_DATA,
    input  logic                 BUS_RD,
    input  logic                 BUS_WR,
    output logic [ABUSWIDTH-1:0] IP_ADD,
    output logic                 IP_RD,
    output logic                 IP_WR,
    output logic [7:0]           IP_DATA_IN,
    input  logic [7:0]           IP_DATA_OUT
);
    localparam logic [ABUSWIDTH-1:0] BASE = ABUSWIDTH'(BASEADDR);
    localparam logic [ABUSWIDTH-1:0] SPAN = ABUSWIDTH'(HIGHADDR) - ABUSWIDTH'(BASEADDR);

    logic [ABUSWIDTH-1:0] rel_s;
    logic                 cs_s;
    logic                 rd_prev_q;
    logic                 rd_prev_d;

    // Single unsigned compare covers both range bounds.
    assign rel_s      = BUS_ADD - BASE;
    assign cs_s       = (rel_s <= SPAN);
    assign IP_ADD     = cs_s ? rel_s : {ABUSWIDTH{1'b0}};
    assign IP_RD      = cs_s & BUS_RD;
    assign IP_WR      = cs_s & BUS_WR;
    assign IP_DATA_IN = BUS_DATA;
    assign rd_prev_d  = IP_RD;
    assign BUS_DATA   = rd_prev_q ? IP_DATA_OUT : 8'hzz;

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            rd_prev_q <= 1'b0;
        end else begin
            rd_prev_q <= rd_prev_d;
        end
    end

endmodule

// File: rtl/hit_injector_core.sv
// Register file, shadow copies and pulse sequencer behind the IP_* interface.
module hit_injector_core
    import hit_injector_pkg::*;
#(
    parameter int ABUSWIDTH = 16,
    parameter int ROWS      = 512,
    parameter int COLS      = 56
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ABUSWIDTH-1:0] ip_add,
    input  logic                 ip_rd,
    input  logic                 ip_wr,
    input  logic [7:0]           ip_data_in,
    output logic [7:0]           ip_data_out,
    output logic [ROWS*COLS-1:0] hit,
    output logic                 hit_or,
    output logic                 busy
);
    localparam int N_PIX = ROWS * COLS;

    logic [15:0] pix_q, pix_d, delay_q, delay_d, width_q, width_d, period_q, period_d;
    logic [7:0]  rep_q, rep_d;
    logic        all_q, all_d;
    logic [15:0] w_pix_q, w_pix_d, w_width_q, w_width_d, w_period_q, w_period_d;
    logic [7:0]  w_rep_q, w_rep_d;
    logic        w_all_q, w_all_d;
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  pulse_q, pulse_d, rd_data_q, rd_data_d;
    logic        done_q, done_d, addr_err_q, addr_err_d, busy_q, busy_d, hit_or_q, hit_or_d;
    logic [N_PIX-1:0] hit_q, hit_d, mask_s;

    logic [3:0]  off_s;
    logic        in_map_s, wr_s, rd_s, srst_s, start_s, stop_s;
    logic [15:0] w_len_s, low_len_s;
    logic [7:0]  pulse_next_s;

    assign off_s        = ip_add[3:0];
    assign in_map_s     = (ip_add[ABUSWIDTH-1:4] == {(ABUSWIDTH-4){1'b0}});
    assign wr_s         = ip_wr & in_map_s;
    assign rd_s         = ip_rd & in_map_s;
    assign srst_s       = wr_s && (off_s == REG_CTRL);
    assign start_s      = wr_s && (off_s == REG_STATUS);
    assign stop_s       = wr_s && (off_s == REG_STOP);
    assign w_len_s      = max1(w_width_q);
    // LOW uses the effective width so a zero WIDTH still yields PERIOD spacing.
    assign low_len_s    = (w_period_q > w_len_s) ? (w_period_q - w_len_s) : 16'd1;
    assign pulse_next_s = pulse_q + 8'd1;

    // Target pattern from the shadowed pixel selection.
    always_comb begin
        if (w_all_q) begin
            mask_s = {N_PIX{1'b1}};
        end else if (addr_err_q) begin
            mask_s = {N_PIX{1'b0}};
        end else begin
            mask_s = {{(N_PIX-1){1'b0}}, 1'b1} << w_pix_q;
        end
    end

    // Configuration writes, read mux and sequencer next state.
    always_comb begin
        pix_d = pix_q;  delay_d = delay_q;  width_d = width_q;  period_d = period_q;
        rep_d = rep_q;  all_d = all_q;
        w_pix_d = w_pix_q;  w_width_d = w_width_q;  w_period_d = w_period_q;
        w_rep_d = w_rep_q;  w_all_d = w_all_q;
        state_d = state_q;  cnt_d = cnt_q;  pulse_d = pulse_q;
        done_d = done_q;  addr_err_d = addr_err_q;  rd_data_d = rd_data_q;

        if (wr_s) begin
            case (off_s)
                REG_PIX_LO:   pix_d[7:0]     = ip_data_in;
                REG_PIX_HI:   pix_d[15:8]    = ip_data_in;
                REG_DELAY_LO: delay_d[7:0]   = ip_data_in;
                REG_DELAY_HI: delay_d[15:8]  = ip_data_in;
                REG_WIDTH_LO: width_d[7:0]   = ip_data_in;
                REG_WIDTH_HI: width_d[15:8]  = ip_data_in;
                REG_PER_LO:   period_d[7:0]  = ip_data_in;
                REG_PER_HI:   period_d[15:8] = ip_data_in;
                REG_REPEAT:   rep_d          = ip_data_in;
                REG_ALL:      all_d          = ip_data_in[0];
                default:      all_d          = all_q;
            endcase
        end else begin
            all_d = all_q;
        end

        if (rd_s) begin
            case (off_s)
                REG_CTRL:     rd_data_d = VERSION;
                REG_STATUS:   rd_data_d = {5'b0, addr_err_q, done_q, busy_q};
                REG_PIX_LO:   rd_data_d = pix_q[7:0];
                REG_PIX_HI:   rd_data_d = pix_q[15:8];
                REG_DELAY_LO: rd_data_d = delay_q[7:0];
                REG_DELAY_HI: rd_data_d = delay_q[15:8];
                REG_WIDTH_LO: rd_data_d = width_q[7:0];
                REG_WIDTH_HI: rd_data_d = width_q[15:8];
                REG_PER_LO:   rd_data_d = period_q[7:0];
                REG_PER_HI:   rd_data_d = period_q[15:8];
                REG_REPEAT:   rd_data_d = rep_q;
                REG_ALL:      rd_data_d = {7'b0, all_q};
                default:      rd_data_d = 8'h00;
            endcase
        end else begin
            rd_data_d = rd_data_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_s && !stop_s) begin
                    w_pix_d    = pix_q;
                    w_width_d  = width_q;
                    w_period_d = period_q;
                    w_rep_d    = rep_q;
                    w_all_d    = all_q;
                    done_d     = 1'b0;
                    addr_err_d = (32'(pix_q) >= N_PIX) && !all_q;
                    pulse_d    = 8'd0;
                    if (delay_q != 16'd0) begin
                        state_d = ST_DELAY;
                        cnt_d   = delay_q - 16'd1;
                    end else begin
                        state_d = ST_HIGH;
                        cnt_d   = max1(width_q) - 16'd1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DELAY: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_HIGH;
                    cnt_d   = w_len_s - 16'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_HIGH: begin
                if (cnt_q == 16'd0) begin
                    pulse_d = (pulse_q == 8'hFF) ? pulse_q : pulse_next_s;
                    if ((w_rep_q != 8'd0) && (pulse_next_s == w_rep_q)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_LOW;
                        cnt_d   = low_len_s - 16'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_LOW: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_HIGH;
                    cnt_d   = w_len_s - 16'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (stop_s && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            cnt_d   = 16'd0;
        end else begin
            cnt_d = cnt_d;
        end
    end

    // HIT follows the current state; a STOP blanks it on the same edge.
    always_comb begin
        busy_d   = (state_q != ST_IDLE) && !stop_s;
        hit_d    = ((state_q == ST_HIGH) && !stop_s) ? mask_s : {N_PIX{1'b0}};
        hit_or_d = |hit_d;
    end

    // All state: async bus reset plus soft reset from a control write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || srst_s) begin
            pix_q <= 16'd0;  delay_q <= 16'd0;  width_q <= 16'd0;  period_q <= 16'd0;
            rep_q <= 8'd0;   all_q <= 1'b0;
            w_pix_q <= 16'd0;  w_width_q <= 16'd0;  w_period_q <= 16'd0;
            w_rep_q <= 8'd0;   w_all_q <= 1'b0;
            state_q <= ST_IDLE;  cnt_q <= 16'd0;  pulse_q <= 8'd0;
            done_q <= 1'b0;  addr_err_q <= 1'b0;  busy_q <= 1'b0;  rd_data_q <= 8'd0;
            hit_q <= {N_PIX{1'b0}};  hit_or_q <= 1'b0;
        end else begin
            pix_q <= pix_d;  delay_q <= delay_d;  width_q <= width_d;  period_q <= period_d;
            rep_q <= rep_d;  all_q <= all_d;
            w_pix_q <= w_pix_d;  w_width_q <= w_width_d;  w_period_q <= w_period_d;
            w_rep_q <= w_rep_d;  w_all_q <= w_all_d;
            state_q <= state_d;  cnt_q <= cnt_d;  pulse_q <= pulse_d;
            done_q <= done_d;  addr_err_q <= addr_err_d;  busy_q <= busy_d;  rd_data_q <= rd_data_d;
            hit_q <= hit_d;  hit_or_q <= hit_or_d;
        end
    end

    assign ip_data_out = rd_data_q;
    assign hit         = hit_q;
    assign hit_or      = hit_or_q;
    assign busy        = busy_q;

endmodule

// File: rtl/hit_injector.sv
// Basil wrapper: bus_to_ip decode in front of the hit_injector core.
module hit_injector #(
    parameter logic [15:0] BASEADDR  = 16'h0000,
    parameter logic [15:0] HIGHADDR  = 16'h0000,
    parameter int          ABUSWIDTH = 16,
    parameter int          ROWS      = 512,
    parameter int          COLS      = 56
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    inout  wire  [7:0]           BUS_DATA,
    input  logic                 BUS_RD,
    input  logic                 BUS_WR,
    output logic [ROWS*COLS-1:0] HIT,
    output logic                 HIT_OR,
    output logic                 BUSY
);
    logic [ABUSWIDTH-1:0] ip_add_s;
    logic                 ip_rd_s;
    logic                 ip_wr_s;
    logic [7:0]           ip_data_in_s;
    logic [7:0]           ip_data_out_s;

    bus_to_ip #(
        .BASEADDR (BASEADDR),
        .HIGHADDR (HIGHADDR),
        .ABUSWIDTH(ABUSWIDTH)
    ) u_bus_to_ip (
        .BUS_CLK    (BUS_CLK),
        .BUS_RST    (BUS_RST),
        .BUS_ADD    (BUS_ADD),
        .BUS_DATA   (BUS_DATA),
        .BUS_RD     (BUS_RD),
        .BUS_WR     (BUS_WR),
        .IP_ADD     (ip_add_s),
        .IP_RD      (ip_rd_s),
        .IP_WR      (ip_wr_s),
        .IP_DATA_IN (ip_data_in_s),
        .IP_DATA_OUT(ip_data_out_s)
    );

    hit_injector_core #(
        .ABUSWIDTH(ABUSWIDTH),
        .ROWS     (ROWS),
        .COLS     (COLS)
    ) u_core (
        .clk        (BUS_CLK),
        .rst        (BUS_RST),
        .ip_add     (ip_add_s),
        .ip_rd      (ip_rd_s),
        .ip_wr      (ip_wr_s),
        .ip_data_in (ip_data_in_s),
        .ip_data_out(ip_data_out_s),
        .hit        (HIT),
        .hit_or     (HIT_OR),
        .busy       (BUSY)
    );

endmodule

// File: tb/tb_hit_injector.sv
// Self-checking bench: directed and randomized pulse trains against a timing model.
module tb_hit_injector;
    localparam int          ROWS  = 16;
    localparam int          COLS  = 4;
    localparam int          N_PIX = ROWS * COLS;
    localparam logic [15:0] BASE  = 16'h4000;
    localparam int          NEVER = 1 << 30;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [15:0]      bus_add = 16'h0000;
    logic             bus_rd = 1'b0;
    logic             bus_wr = 1'b0;
    logic [7:0]       tb_dout = 8'h00;
    logic             tb_drv = 1'b0;
    wire  [7:0]       bus_data;
    logic [N_PIX-1:0] hit;
    logic             hit_or;
    logic             busy;
    int               n_pass = 0;
    int               n_fail = 0;
    int               n_total = 0;
    logic [7:0]       rdata;

    assign bus_data = tb_drv ? tb_dout : 8'hzz;

    always #5 clk = ~clk;

    hit_injector #(
        .BASEADDR (BASE),
        .HIGHADDR (16'h400F),
        .ABUSWIDTH(16),
        .ROWS     (ROWS),
        .COLS     (COLS)
    ) dut (
        .BUS_CLK (clk),
        .BUS_RST (rst),
        .BUS_ADD (bus_add),
        .BUS_DATA(bus_data),
        .BUS_RD  (bus_rd),
        .BUS_WR  (bus_wr),
        .HIT     (hit),
        .HIT_OR  (hit_or),
        .BUSY    (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] off, input logic [7:0] d);
        @(negedge clk);
        bus_add = BASE + {12'd0, off};
        bus_wr  = 1'b1;
        tb_dout = d;
        tb_drv  = 1'b1;
        @(negedge clk);
        bus_wr  = 1'b0;
        tb_drv  = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] off, output logic [7:0] d);
        @(negedge clk);
        bus_add = BASE + {12'd0, off};
        bus_rd  = 1'b1;
        @(negedge clk);
        bus_rd  = 1'b0;
        d = bus_data;
    endtask

    // Program, START, then compare every cycle against the rule-derived pulse timing.
    task automatic run_seq(input int pix, input bit all, input int d, input int w, input int p,
                           input int r, input int inj_k, input logic [3:0] inj_off,
                           input logic [7:0] inj_data, input string name);
        int wl, s, first, end_k, stop_k, ncyc;
        bit hi, bz, err_e;
        logic [N_PIX-1:0] mask;
        logic [7:0] st;
        wl     = (w == 0) ? 1 : w;
        s      = (p > wl) ? p : wl + 1;
        first  = 1 + d;
        end_k  = (r == 0) ? NEVER : first + (r - 1) * s + wl;
        stop_k = (inj_k >= 0 && inj_off == 4'd11) ? inj_k + 1 : NEVER;
        ncyc   = ((stop_k < end_k) ? stop_k : end_k) + 3;
        err_e  = (pix >= N_PIX) && !all;
        if (all) mask = {N_PIX{1'b1}};
        else if (err_e) mask = {N_PIX{1'b0}};
        else mask = {{(N_PIX-1){1'b0}}, 1'b1} << pix;

        bus_write(4'd2, 8'(pix));
        bus_write(4'd3, 8'(pix >> 8));
        bus_write(4'd4, 8'(d));
        bus_write(4'd5, 8'(d >> 8));
        bus_write(4'd6, 8'(w));
        bus_write(4'd7, 8'(w >> 8));
        bus_write(4'd8, 8'(p));
        bus_write(4'd9, 8'(p >> 8));
        bus_write(4'd10, 8'(r));
        bus_write(4'd12, {7'd0, all});
        bus_write(4'd1, 8'h01);

        for (int k = 0; k < ncyc; k++) begin
            hi = (k >= first) && (k < stop_k) && (((k - first) % s) < wl) &&
                 ((r == 0) || (((k - first) / s) < r));
            bz = (k >= 1) && (k < end_k) && (k < stop_k);
            check($sformatf("%s hit k=%0d", name, k), 64'(hit), hi ? 64'(mask) : 64'd0);
            check($sformatf("%s hit_or k=%0d", name, k), {63'd0, hit_or},
                  {63'd0, hi && (mask != {N_PIX{1'b0}})});
            check($sformatf("%s busy k=%0d", name, k), {63'd0, busy}, {63'd0, bz});
            if (k == inj_k) begin
                bus_add = BASE + {12'd0, inj_off};
                bus_wr  = 1'b1;
                tb_dout = inj_data;
                tb_drv  = 1'b1;
            end
            @(negedge clk);
            bus_wr = 1'b0;
            tb_drv = 1'b0;
        end
        bus_read(4'd1, st);
        check({name, " status"}, {56'd0, st}, {56'd0, 5'd0, err_e, 1'b1, 1'b0});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset hit", 64'(hit), 64'd0);
        check("reset hit_or", {63'd0, hit_or}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        bus_read(4'd0, rdata);
        check("version", {56'd0, rdata}, 64'h01);
        bus_read(4'd1, rdata);
        check("status idle", {56'd0, rdata}, 64'h00);

        run_seq(5, 1'b0, 3, 2, 0, 1, -1, 4'd15, 8'h00, "single");
        run_seq(9, 1'b0, 0, 4, 10, 3, -1, 4'd15, 8'h00, "train3");
        run_seq(17, 1'b0, 1, 5, 2, 3, -1, 4'd15, 8'h00, "p_lt_w");
        run_seq(30, 1'b0, 2, 0, 4, 3, -1, 4'd15, 8'h00, "w_zero");
        run_seq(N_PIX, 1'b0, 2, 2, 4, 2, -1, 4'd15, 8'h00, "addr_err");
        run_seq(N_PIX, 1'b1, 1, 3, 5, 2, -1, 4'd15, 8'h00, "all");
        run_seq(3, 1'b0, 0, 4, 10, 0, 2, 4'd11, 8'h00, "stop_high");
        run_seq(40, 1'b0, 1, 3, 6, 3, 3, 4'd1, 8'h01, "start_busy");
        run_seq(12, 1'b0, 0, 2, 5, 3, 2, 4'd6, 8'h07, "shadow");
        bus_read(4'd6, rdata);
        check("shadow width readback", {56'd0, rdata}, 64'h07);

        for (int i = 0; i < 8; i++) begin
            run_seq(int'($urandom_range(0, N_PIX - 1)), ($urandom_range(0, 3) == 0),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 7)), int'($urandom_range(1, 3)),
                    -1, 4'd15, 8'h00, $sformatf("rand%0d", i));
        end

        bus_write(4'd0, 8'h00);
        bus_read(4'd6, rdata);
        check("soft reset width", {56'd0, rdata}, 64'h00);
        bus_read(4'd10, rdata);
        check("soft reset repeat", {56'd0, rdata}, 64'h00);
        bus_read(4'd0, rdata);
        check("version after soft reset", {56'd0, rdata}, 64'h01);

        bus_write(4'd4, 8'd20);
        bus_write(4'd6, 8'd2);
        bus_write(4'd1, 8'h01);
        repeat (3) @(negedge clk);
        check("busy mid delay", {63'd0, busy}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async rst hit", 64'(hit), 64'd0);
        check("async rst hit_or", {63'd0, hit_or}, 64'd0);
        check("async rst busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus_read(4'd1, rdata);
        check("status after rst", {56'd0, rdata}, 64'h00);
        bus_read(4'd4, rdata);
        check("delay after rst", {56'd0, rdata}, 64'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
